// File: rtl/md4_stream_driver.sv
// md4_stream_driver: owns a writable message buffer, streams it into an MD4
// core through the core's byte-FIFO input port, and collects the digest bytes
// from the core's output port into a flat DIGEST register (first byte in MSBs).
// Optional feature macro: MD4_DRV_COMPARE_EN adds EXP_DIGEST/MATCH comparison.
`timescale 1ns/1ps
module md4_stream_driver #(
  parameter int unsigned MSG_DEPTH  = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned SIZE_W     = 64,
  parameter int unsigned HASH_BYTES = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    WR_EN,
  input  logic [ADDR_W-1:0]       WR_ADDR,
  input  logic [7:0]              WR_DATA,
  input  logic [SIZE_W-1:0]       MSG_LEN,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR,
  output logic [8*HASH_BYTES-1:0] DIGEST,
`ifdef MD4_DRV_COMPARE_EN
  input  logic [8*HASH_BYTES-1:0] EXP_DIGEST,
  output logic                    MATCH,
`endif
  output logic                    HC_START,
  input  logic                    HC_BUSY,
  input  logic                    HC_DONE,
  output logic [SIZE_W-1:0]       HC_SIZE,
  output logic [7:0]              HC_IN_BYTE,
  output logic                    HC_IN_EMPTY,
  input  logic                    HC_IN_READ,
  input  logic [7:0]              HC_OUT_BYTE,
  output logic                    HC_OUT_FULL,
  input  logic                    HC_OUT_WRITE
);

  localparam int unsigned PTR_W = $clog2(MSG_DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(HASH_BYTES + 1);
  localparam int unsigned DIG_W = 8 * HASH_BYTES;

  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(MSG_DEPTH);
  localparam logic [SIZE_W-1:0] DEPTH_S = SIZE_W'(MSG_DEPTH);
  localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(MSG_DEPTH);
  localparam logic [CNT_W-1:0]  HASH_C  = CNT_W'(HASH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_buf [MSG_DEPTH];
  logic [PTR_W-1:0]  r_len,         w_len_nxt;
  logic [PTR_W-1:0]  r_rd_ptr,      w_rd_ptr_nxt;
  logic [CNT_W-1:0]  r_hash_cnt,    w_hash_cnt_nxt;
  logic              r_busy,        w_busy_nxt;
  logic              r_done,        w_done_nxt;
  logic              r_error,       w_error_nxt;
  logic [DIG_W-1:0]  r_digest,      w_digest_nxt;
  logic              r_hc_start,    w_hc_start_nxt;
  logic [SIZE_W-1:0] r_hc_size,     w_hc_size_nxt;
  logic [7:0]        r_hc_in_byte,  w_rd_byte;
  logic              r_hc_in_empty, w_in_empty_nxt;
  logic              r_hc_out_full, w_out_full_nxt;
`ifdef MD4_DRV_COMPARE_EN
  logic              r_match,       w_match_nxt;
`endif

  // Core BUSY is informational only; completion is keyed off HC_DONE.
  logic w_unused_hc_busy;
  assign w_unused_hc_busy = HC_BUSY;

  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign ERROR       = r_error;
  assign DIGEST      = r_digest;
  assign HC_START    = r_hc_start;
  assign HC_SIZE     = r_hc_size;
  assign HC_IN_BYTE  = r_hc_in_byte;
  assign HC_IN_EMPTY = r_hc_in_empty;
  assign HC_OUT_FULL = r_hc_out_full;
`ifdef MD4_DRV_COMPARE_EN
  assign MATCH       = r_match;
`endif

  // Message buffer: writable only while idle, out-of-range addresses dropped.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && WR_EN && ({1'b0, WR_ADDR} < DEPTH_A)) begin
      r_buf[WR_ADDR] <= WR_DATA;
    end
  end

  // Byte presented to the core next cycle: buffer entry at the next read pointer.
  always_comb begin
    w_rd_byte = '0;
    if (w_rd_ptr_nxt < DEPTH_P) begin
      w_rd_byte = r_buf[ADDR_W'(w_rd_ptr_nxt)];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_hash_cnt_nxt = r_hash_cnt;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_error_nxt    = r_error;
    w_digest_nxt   = r_digest;
    w_hc_start_nxt = r_hc_start;
    w_hc_size_nxt  = r_hc_size;
    w_in_empty_nxt = r_hc_in_empty;
    w_out_full_nxt = r_hc_out_full;
`ifdef MD4_DRV_COMPARE_EN
    w_match_nxt    = r_match;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          if (MSG_LEN <= DEPTH_S) begin
            w_len_nxt      = PTR_W'(MSG_LEN);
            w_hc_size_nxt  = MSG_LEN;
            w_rd_ptr_nxt   = '0;
            w_hash_cnt_nxt = '0;
            w_digest_nxt   = '0;
            w_error_nxt    = 1'b0;
            w_hc_start_nxt = 1'b1;
            w_busy_nxt     = 1'b1;
            w_in_empty_nxt = (MSG_LEN == '0);
            w_out_full_nxt = 1'b0;
`ifdef MD4_DRV_COMPARE_EN
            w_match_nxt    = 1'b0;
`endif
            w_state_nxt    = S_RUN;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Input side: advance on each read of a non-empty stream.
        if (HC_IN_READ) begin
          if (r_hc_in_empty) begin
            w_error_nxt = 1'b1;
          end else begin
            w_rd_ptr_nxt   = r_rd_ptr + PTR_W'(1);
            w_in_empty_nxt = (w_rd_ptr_nxt == r_len);
          end
        end
        // Output side: pack digest bytes MSB-first until full.
        if (HC_OUT_WRITE) begin
          if (r_hc_out_full) begin
            w_error_nxt = 1'b1;
          end else begin
            for (int unsigned b = 0; b < HASH_BYTES; b++) begin
              if (r_hash_cnt == CNT_W'(b)) begin
                w_digest_nxt[8*(HASH_BYTES-1-b) +: 8] = HC_OUT_BYTE;
              end
            end
            w_hash_cnt_nxt = r_hash_cnt + CNT_W'(1);
            w_out_full_nxt = (w_hash_cnt_nxt == HASH_C);
          end
        end
        // Completion check sees a same-cycle final write already counted.
        if (HC_DONE) begin
          if (w_hash_cnt_nxt != HASH_C) begin
            w_error_nxt = 1'b1;
          end
          w_hc_start_nxt = 1'b0;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
          w_in_empty_nxt = 1'b1;
          w_out_full_nxt = 1'b1;
          w_state_nxt    = S_FIN;
        end
      end

      S_FIN: begin
`ifdef MD4_DRV_COMPARE_EN
        w_match_nxt = (r_digest == EXP_DIGEST) && !r_error;
`endif
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_len         <= '0;
      r_rd_ptr      <= '0;
      r_hash_cnt    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_digest      <= '0;
      r_hc_start    <= 1'b0;
      r_hc_size     <= '0;
      r_hc_in_byte  <= '0;
      r_hc_in_empty <= 1'b1;
      r_hc_out_full <= 1'b1;
    end else begin
      r_len         <= w_len_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_hash_cnt    <= w_hash_cnt_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_digest      <= w_digest_nxt;
      r_hc_start    <= w_hc_start_nxt;
      r_hc_size     <= w_hc_size_nxt;
      r_hc_in_byte  <= w_rd_byte;
      r_hc_in_empty <= w_in_empty_nxt;
      r_hc_out_full <= w_out_full_nxt;
    end
  end

`ifdef MD4_DRV_COMPARE_EN
  // Digest compare result, valid from the end of FIN until the next START.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_match <= 1'b0;
    end else begin
      r_match <= w_match_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_md4_stream_driver.sv
// Bench for md4_stream_driver: a transaction-level model of the driver is
// advanced on every clock from the bench-driven inputs, and one negedge
// process compares every DUT output against it. A core emulator drives the
// HC_* side. Honours MD4_DRV_COMPARE_EN for the EXP_DIGEST/MATCH ports.
`timescale 1ns/1ps
module tb_md4_stream_driver;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         WR_EN;
  logic [7:0]   WR_ADDR;
  logic [7:0]   WR_DATA;
  logic [63:0]  MSG_LEN;
  logic         START;
  logic         BUSY;
  logic         DONE;
  logic         ERROR;
  logic [127:0] DIGEST;
`ifdef MD4_DRV_COMPARE_EN
  logic [127:0] EXP_DIGEST;
  logic         MATCH;
`endif
  logic         HC_START;
  logic         HC_BUSY;
  logic         HC_DONE;
  logic [63:0]  HC_SIZE;
  logic [7:0]   HC_IN_BYTE;
  logic         HC_IN_EMPTY;
  logic         HC_IN_READ;
  logic [7:0]   HC_OUT_BYTE;
  logic         HC_OUT_FULL;
  logic         HC_OUT_WRITE;

  md4_stream_driver #(
    .MSG_DEPTH(256), .ADDR_W(8), .SIZE_W(64), .HASH_BYTES(16)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .MSG_LEN(MSG_LEN), .START(START),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .DIGEST(DIGEST),
`ifdef MD4_DRV_COMPARE_EN
    .EXP_DIGEST(EXP_DIGEST), .MATCH(MATCH),
`endif
    .HC_START(HC_START), .HC_BUSY(HC_BUSY), .HC_DONE(HC_DONE),
    .HC_SIZE(HC_SIZE), .HC_IN_BYTE(HC_IN_BYTE), .HC_IN_EMPTY(HC_IN_EMPTY),
    .HC_IN_READ(HC_IN_READ), .HC_OUT_BYTE(HC_OUT_BYTE),
    .HC_OUT_FULL(HC_OUT_FULL), .HC_OUT_WRITE(HC_OUT_WRITE)
  );

  always #5 CLK = ~CLK;
  assign HC_BUSY = HC_START;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the driver ----------------
  logic [7:0]   mbuf [256];
  bit           m_run, m_fin, m_err, m_match;
  logic [127:0] m_dig;
  logic [63:0]  m_size;
  int           m_len, m_rd, m_wr;

  task automatic model_step();
    if (!RESET_N) begin
      m_run = 0; m_fin = 0; m_err = 0; m_match = 0;
      m_dig = '0; m_size = '0; m_len = 0; m_rd = 0; m_wr = 0;
    end else if (m_fin) begin
`ifdef MD4_DRV_COMPARE_EN
      m_match = (m_dig == EXP_DIGEST) && !m_err;
`endif
      m_fin = 0;
    end else if (m_run) begin
      if (HC_IN_READ) begin
        if (m_rd < m_len) m_rd++;
        else m_err = 1;
      end
      if (HC_OUT_WRITE) begin
        if (m_wr < 16) begin
          m_dig[8*(15-m_wr) +: 8] = HC_OUT_BYTE;
          m_wr++;
        end else m_err = 1;
      end
      if (HC_DONE) begin
        if (m_wr != 16) m_err = 1;
        m_run = 0;
        m_fin = 1;
      end
    end else begin
      if (WR_EN) mbuf[WR_ADDR] = WR_DATA;
      if (START) begin
        if (MSG_LEN <= 64'd256) begin
          m_run = 1; m_len = int'(MSG_LEN); m_size = MSG_LEN;
          m_rd = 0; m_wr = 0; m_dig = '0; m_err = 0; m_match = 0;
        end else m_err = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      check("busy",      128'(BUSY),        128'(m_run));
      check("done",      128'(DONE),        128'(m_fin));
      check("error",     128'(ERROR),       128'(m_err));
      check("digest",    DIGEST,            m_dig);
      check("hc_start",  128'(HC_START),    128'(m_run));
      check("hc_size",   128'(HC_SIZE),     128'(m_size));
      check("in_empty",  128'(HC_IN_EMPTY), 128'(!m_run || (m_rd == m_len)));
      check("out_full",  128'(HC_OUT_FULL), 128'(!m_run || (m_wr == 16)));
      if (m_run && m_rd < m_len) check("in_byte", 128'(HC_IN_BYTE), 128'(mbuf[m_rd]));
`ifdef MD4_DRV_COMPARE_EN
      check("match",     128'(MATCH),       128'(m_match));
`endif
      if (DONE) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] ob [17];
  logic [7:0] got [$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_byte(input int addr, input logic [7:0] data);
    WR_EN = 1'b1; WR_ADDR = 8'(addr); WR_DATA = data;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic do_start(input int len, input bit hold);
    MSG_LEN = 64'(len);
    START   = 1'b1;
    tick();
    if (!hold) START = 1'b0;
  endtask

  task automatic set_ob(input logic [127:0] d);
    for (int i = 0; i < 16; i++) ob[i] = d[8*(15-i) +: 8];
  endtask

  // Core emulator: drain input stream, emit n_out digest bytes, signal done.
  task automatic core_run(input int n_out, input int gap, input int extra_rd,
                          input bit done_last, input bit overlap, input bit wr_noise);
    int  guard;
    int  wi;
    bit  fin;
    got.delete();
    wi = 0; guard = 0; fin = 0;
    while (!HC_START && guard < 20) begin tick(); guard++; end
    check("hc_start_seen", 128'(HC_START), 128'(1));
    guard = 0;
    while (!HC_IN_EMPTY && guard < 600) begin
      HC_IN_READ = 1'b1;
      got.push_back(HC_IN_BYTE);
      if (overlap && wi < n_out - 1) begin
        HC_OUT_WRITE = 1'b1; HC_OUT_BYTE = ob[wi]; wi++;
      end
      if (wr_noise) begin
        WR_EN = 1'b1; WR_ADDR = 8'($urandom); WR_DATA = 8'($urandom);
      end
      tick();
      HC_IN_READ = 1'b0; HC_OUT_WRITE = 1'b0; WR_EN = 1'b0;
      repeat (gap) tick();
      guard++;
    end
    check("read_drained", 128'(HC_IN_EMPTY), 128'(1));
    repeat (extra_rd) begin
      HC_IN_READ = 1'b1;
      tick();
      HC_IN_READ = 1'b0;
    end
    while (wi < n_out) begin
      HC_OUT_WRITE = 1'b1; HC_OUT_BYTE = ob[wi];
      if (done_last && wi == n_out - 1) begin HC_DONE = 1'b1; fin = 1; end
      wi++;
      tick();
      HC_OUT_WRITE = 1'b0; HC_DONE = 1'b0;
      if (!fin && $urandom_range(0, 2) == 0) tick();
    end
    if (!fin) begin
      HC_DONE = 1'b1;
      tick();
      HC_DONE = 1'b0;
    end
    check("done_pulse", 128'(DONE), 128'(1));
    check("busy_in_fin", 128'(BUSY), 128'(0));
    START = 1'b0;
    tick();
    check("done_drop", 128'(DONE), 128'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] exp_d;
    logic [7:0]   snap [12];
    int           dc0;
    int           len, n_out, gap, extra;
    bit           dl, ov, exp_err;

    RESET_N = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; MSG_LEN = '0; START = 1'b0;
    HC_DONE = 1'b0; HC_IN_READ = 1'b0; HC_OUT_BYTE = '0; HC_OUT_WRITE = 1'b0;
`ifdef MD4_DRV_COMPARE_EN
    EXP_DIGEST = '0;
`endif
    tick();
    chk_en = 1'b1;
    check("rst_busy",   128'(BUSY),        128'(0));
    check("rst_start",  128'(HC_START),    128'(0));
    check("rst_empty",  128'(HC_IN_EMPTY), 128'(1));
    check("rst_full",   128'(HC_OUT_FULL), 128'(1));
    check("rst_digest", DIGEST,            128'(0));
    tick();
    RESET_N = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) wr_byte(i, 8'($urandom));

    // Known vector "1234567891234567" with its MD4 digest returned by the core.
    for (int i = 0; i < 16; i++) wr_byte(i, 8'(8'h31 + ((i < 9) ? i : i - 9)));
    exp_d = 128'h2baa0645e8c33c14022716e6da14b81c;
    set_ob(exp_d);
`ifdef MD4_DRV_COMPARE_EN
    EXP_DIGEST = exp_d;
`endif
    do_start(16, 0);
    core_run(16, 0, 0, 1, 0, 0);
    check("t1_digest", DIGEST, 128'h2baa0645e8c33c14022716e6da14b81c);
    check("t1_error",  128'(ERROR), 128'(0));
    check("t1_first",  128'(got[0]),  128'(8'h31));
    check("t1_last",   128'(got[15]), 128'(8'h37));
`ifdef MD4_DRV_COMPARE_EN
    check("t1_match",  128'(MATCH), 128'(1));
`endif

    // Five-byte message, slow reader, one extra read past the end.
    for (int i = 0; i < 5; i++) wr_byte(i, 8'(8'hA0 + i));
    do_start(5, 0);
    core_run(16, 3, 1, 0, 0, 0);
    check("t2_count", 128'(got.size()), 128'(5));
    for (int i = 0; i < 5; i++) check("t2_byte", 128'(got[i]), 128'(8'hA0 + i));
    check("t2_error", 128'(ERROR), 128'(1));

    // Seventeen output writes: the last one is dropped.
    for (int i = 0; i < 17; i++) ob[i] = 8'(8'h10 + i);
    do_start(8, 0);
    core_run(17, 0, 0, 0, 0, 0);
    check("t3_digest", DIGEST, 128'h101112131415161718191a1b1c1d1e1f);
    check("t3_error",  128'(ERROR), 128'(1));

    // Empty message is legal.
    set_ob({$urandom, $urandom, $urandom, $urandom});
    do_start(0, 0);
    core_run(16, 0, 0, 1, 0, 0);
    check("t4_count", 128'(got.size()), 128'(0));
    check("t4_error", 128'(ERROR), 128'(0));

    // Oversized length is refused.
    do_start(300, 0);
    repeat (3) begin
      check("t4_len_error", 128'(ERROR),    128'(1));
      check("t4_len_busy",  128'(BUSY),     128'(0));
      check("t4_len_start", 128'(HC_START), 128'(0));
      tick();
    end

    // Reset in the middle of a run, then a clean restart.
    do_start(20, 0);
    repeat (8) begin HC_IN_READ = 1'b1; tick(); HC_IN_READ = 1'b0; end
    RESET_N = 1'b0;
    tick();
    check("t5_busy",   128'(BUSY),        128'(0));
    check("t5_start",  128'(HC_START),    128'(0));
    check("t5_digest", DIGEST,            128'(0));
    check("t5_empty",  128'(HC_IN_EMPTY), 128'(1));
    RESET_N = 1'b1;
    tick();
    do_start(20, 0);
    core_run(16, 1, 0, 0, 1, 0);
    check("t5_byte0", 128'(got[0]), 128'(mbuf[0]));
    check("t5_count", 128'(got.size()), 128'(20));

    // START held through a run with buffer writes attempted mid-run.
    for (int i = 0; i < 12; i++) snap[i] = mbuf[i];
    set_ob({$urandom, $urandom, $urandom, $urandom});
    exp_d = '0;
    for (int i = 0; i < 16; i++) exp_d[8*(15-i) +: 8] = ob[i];
    dc0 = done_cnt;
    do_start(12, 1);
    core_run(16, 1, 0, 1, 1, 1);
    check("t6_one_done", 128'(done_cnt - dc0), 128'(1));
    check("t6_idle",     128'(BUSY), 128'(0));
    do_start(12, 0);
    core_run(16, 0, 0, 0, 0, 0);
    check("t6_digest", DIGEST, exp_d);
    for (int i = 0; i < 12; i++) check("t6_buf", 128'(got[i]), 128'(snap[i]));

    // Randomised runs.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 4)) wr_byte(int'($urandom_range(0, 255)), 8'($urandom));
      len   = (r == 0) ? 256 : int'($urandom_range(0, 256));
      n_out = int'($urandom_range(15, 17));
      gap   = int'($urandom_range(0, 2));
      extra = ($urandom_range(0, 3) == 0) ? 1 : 0;
      dl    = 1'($urandom_range(0, 1));
      ov    = 1'($urandom_range(0, 1));
      for (int i = 0; i < 17; i++) ob[i] = 8'($urandom);
      exp_err = (extra != 0) || (n_out != 16);
      do_start(len, 0);
      core_run(n_out, gap, extra, dl, ov, 0);
      check("rand_count", 128'(got.size()), 128'(len));
      check("rand_error", 128'(ERROR), 128'(exp_err));
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
